// File: rtl/duel_reaction_controller_pkg.sv
// -----------------------------------------------------------------------------
// duel_reaction_controller_pkg
// Shared definitions for the duel reaction controller: FSM state encoding,
// counter_flag codes, winner codes, LFSR seed, delay width and the
// winner-selection helper used when a round completes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package duel_reaction_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_t;

  localparam logic [1:0] FLAG_CLR  = 2'b00;
  localparam logic [1:0] FLAG_HOLD = 2'b01;
  localparam logic [1:0] FLAG_RUN  = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Wide enough for MIN_DELAY_MS + SPAN_MS at the default 2000 + 4000 ms.
  localparam int DELAY_W = 16;

  // Smaller time wins; a round where nobody pressed has no winner even
  // though both times read CNT_MAX.
  function automatic logic [1:0] pick_winner(input logic [9:0] ta,
                                             input logic [9:0] tb,
                                             input logic       any_cap);
    logic [1:0] w;
    if (!any_cap)     w = WIN_NONE;
    else if (ta < tb) w = WIN_A;
    else if (tb < ta) w = WIN_B;
    else              w = WIN_TIE;
    return w;
  endfunction

endpackage

// File: rtl/duel_reaction_controller_if.sv
// -----------------------------------------------------------------------------
// duel_reaction_controller_if
// Bundles the button inputs, the shared ms counter value and all round
// results of the duel reaction controller.
//   master : drives start/stop_a/stop_b/cnt_val, observes results
//   slave  : the controller itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface duel_reaction_controller_if;
  logic       start;
  logic       stop_a;
  logic       stop_b;
  logic [9:0] cnt_val;
  logic [1:0] counter_flag;
  logic       LED;
  logic [9:0] time_a;
  logic [9:0] time_b;
  logic       foul_a;
  logic       foul_b;
  logic [1:0] winner;
  logic       busy;

  modport master (
    output start, stop_a, stop_b, cnt_val,
    input  counter_flag, LED, time_a, time_b, foul_a, foul_b, winner, busy
  );

  modport slave (
    input  start, stop_a, stop_b, cnt_val,
    output counter_flag, LED, time_a, time_b, foul_a, foul_b, winner, busy
  );
endinterface

// File: rtl/duel_reaction_controller_lfsr_delay_gen.sv
// -----------------------------------------------------------------------------
// lfsr_delay_gen
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) folded into a
// pre-delay in [MIN_DELAY_MS, MIN_DELAY_MS + SPAN_MS]. The parent samples
// delay_ms on the start edge.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (LFSR -> 16'hACE1)
//   delay_ms out  candidate pre-delay, ms
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lfsr_delay_gen
  import duel_reaction_controller_pkg::*;
#(
  parameter int MIN_DELAY_MS = 2000,
  parameter int SPAN_MS      = 4000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [DELAY_W-1:0] delay_ms
);
  // Raw field is the smallest power of two covering SPAN_MS, so a single
  // subtract folds any raw value into [0, SPAN_MS]. For SPAN_MS = 4000 this
  // is lfsr[11:0].
  localparam int R_W = $clog2(SPAN_MS + 1);

  logic [15:0]      lfsr_q, lfsr_d;
  logic [R_W-1:0]   r_raw;
  logic [DELAY_W-1:0] r_fold;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    r_raw  = lfsr_q[R_W-1:0];
    r_fold = DELAY_W'(r_raw);
    if (r_fold > DELAY_W'(SPAN_MS)) r_fold = r_fold - DELAY_W'(SPAN_MS);
    delay_ms = DELAY_W'(MIN_DELAY_MS) + r_fold;
  end
endmodule

// File: rtl/duel_reaction_controller.sv
// -----------------------------------------------------------------------------
// duel_reaction_controller
// Sequencer for the shared ms reaction counter in a two-player duel: random
// pre-delay, counter control, stop-button arbitration and result latching.
// Ports:
//   clk_50M  in  system clock
//   rst_n    in  asynchronous active-low reset
//   bus      slave side of duel_reaction_controller_if:
//            start/stop_a/stop_b (level buttons), cnt_val (counter value) in;
//            counter_flag, LED, time_a/b, foul_a/b, winner, busy out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module duel_reaction_controller
  import duel_reaction_controller_pkg::*;
#(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int SPAN_MS      = 4000,
  parameter int CNT_MAX      = 999
) (
  input  logic                        clk_50M,
  input  logic                        rst_n,
  duel_reaction_controller_if.slave   bus
);
  localparam int         PRE_W     = $clog2(CLK_PER_MS + 1);
  localparam logic [9:0] CNT_MAX_V = 10'(CNT_MAX);

  // Two synchroniser flops, a history flop and a registered edge pulse:
  // a pin edge is acted on by the FSM three cycles later.
  logic [2:0] pin_raw, sync1_q, sync2_q, sync3_q, edge_q;
  logic       start_edge, stop_a_edge, stop_b_edge;

  assign pin_raw = {bus.stop_b, bus.stop_a, bus.start};

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= pin_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  assign start_edge  = edge_q[0];
  assign stop_a_edge = edge_q[1];
  assign stop_b_edge = edge_q[2];

  logic [DELAY_W-1:0] new_delay;

  lfsr_delay_gen #(
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .SPAN_MS      (SPAN_MS)
  ) u_delay (
    .clk      (clk_50M),
    .rst_n    (rst_n),
    .delay_ms (new_delay)
  );

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [9:0]         time_a_q, time_a_d, time_b_q, time_b_d;
  logic               cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic               foul_a_q, foul_a_d, foul_b_q, foul_b_d;
  logic [1:0]         winner_q, winner_d;
  logic               tick, cap_a_new, cap_b_new;
  logic [1:0]         flag;
  logic               led, busy;

  assign tick = (pre_q == PRE_W'(CLK_PER_MS - 1));

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      delay_q  <= '0;
      time_a_q <= '0;
      time_b_q <= '0;
      cap_a_q  <= 1'b0;
      cap_b_q  <= 1'b0;
      foul_a_q <= 1'b0;
      foul_b_q <= 1'b0;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      delay_q  <= delay_d;
      time_a_q <= time_a_d;
      time_b_q <= time_b_d;
      cap_a_q  <= cap_a_d;
      cap_b_q  <= cap_b_d;
      foul_a_q <= foul_a_d;
      foul_b_q <= foul_b_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = tick ? '0 : pre_q + 1'b1;
    delay_d   = delay_q;
    time_a_d  = time_a_q;
    time_b_d  = time_b_q;
    cap_a_d   = cap_a_q;
    cap_b_d   = cap_b_q;
    foul_a_d  = foul_a_q;
    foul_b_d  = foul_b_q;
    winner_d  = winner_q;
    cap_a_new = cap_a_q | stop_a_edge;
    cap_b_new = cap_b_q | stop_b_edge;
    flag      = FLAG_CLR;
    led       = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (state_q == ST_DONE) flag = FLAG_HOLD;
        if (start_edge) begin
          state_d  = ST_WAIT;
          pre_d    = '0;
          delay_d  = new_delay;
          time_a_d = '0;
          time_b_d = '0;
          cap_a_d  = 1'b0;
          cap_b_d  = 1'b0;
          foul_a_d = 1'b0;
          foul_b_d = 1'b0;
          winner_d = WIN_NONE;
        end
      end

      ST_WAIT: begin
        busy = 1'b1;
        // A false start beats a delay expiring in the same cycle.
        if (stop_a_edge || stop_b_edge) begin
          state_d  = ST_FOUL;
          foul_a_d = stop_a_edge;
          foul_b_d = stop_b_edge;
          if (stop_a_edge && stop_b_edge) winner_d = WIN_NONE;
          else if (stop_a_edge)           winner_d = WIN_B;
          else                            winner_d = WIN_A;
        end else if (tick) begin
          if (delay_q <= DELAY_W'(1)) state_d = ST_RUN;
          else                        delay_d = delay_q - 1'b1;
        end
      end

      ST_RUN: begin
        flag = FLAG_RUN;
        led  = 1'b1;
        busy = 1'b1;
        if (stop_a_edge && !cap_a_q) time_a_d = bus.cnt_val;
        if (stop_b_edge && !cap_b_q) time_b_d = bus.cnt_val;
        cap_a_d = cap_a_new;
        cap_b_d = cap_b_new;
        if ((cap_a_new && cap_b_new) || (bus.cnt_val == CNT_MAX_V)) begin
          state_d = ST_DONE;
          if (!cap_a_new) time_a_d = CNT_MAX_V;
          if (!cap_b_new) time_b_d = CNT_MAX_V;
          winner_d = pick_winner(time_a_d, time_b_d, cap_a_new | cap_b_new);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.counter_flag = flag;
  assign bus.LED          = led;
  assign bus.busy         = busy;
  assign bus.time_a       = time_a_q;
  assign bus.time_b       = time_b_q;
  assign bus.foul_a       = foul_a_q;
  assign bus.foul_b       = foul_b_q;
  assign bus.winner       = winner_q;
endmodule

// File: tb/tb_duel_reaction_controller.sv
`timescale 1ns/1ps
module tb_duel_reaction_controller;
  localparam int CPM  = 5;
  localparam int MIN  = 20;
  localparam int SPAN = 40;
  localparam int CMAX = 999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  duel_reaction_controller_if bus();

  duel_reaction_controller #(
    .CLK_PER_MS   (CPM),
    .MIN_DELAY_MS (MIN),
    .SPAN_MS      (SPAN),
    .CNT_MAX      (CMAX)
  ) dut (
    .clk_50M (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // Environment model of the shared ms counter: cleared on 00, +1 per ms while 10.
  logic [9:0] cnt_m;
  int         pre_m;
  int         led_cycles;
  assign bus.cnt_val = cnt_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_m <= '0;
      pre_m <= 0;
    end else if (bus.counter_flag == 2'b00) begin
      cnt_m <= '0;
      pre_m <= 0;
    end else if (bus.counter_flag == 2'b10) begin
      if (pre_m == CPM - 1) begin
        pre_m <= 0;
        if (cnt_m < 10'(CMAX)) cnt_m <= cnt_m + 10'd1;
      end else begin
        pre_m <= pre_m + 1;
      end
    end
  end

  always @(posedge clk) if (bus.LED) led_cycles <= led_cycles + 1;
  initial led_cycles = 0;

  int total  = 0;
  int passed = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int w);
    case (w)
      0:       return bus.busy;
      1:       return bus.LED;
      2:       return bus.counter_flag == 2'b01;
      default: return !bus.busy;
    endcase
  endfunction

  task automatic wait_for(input int w, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (cond(w)) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    cyc(4);
    bus.start = 1'b0;
  endtask

  // Expected winner from the rules: lower time wins, no presses -> none.
  function automatic logic [1:0] ref_winner(input int pa, input int pb);
    int ta, tb;
    ta = (pa > 0) ? pa : CMAX;
    tb = (pb > 0) ? pb : CMAX;
    if (pa <= 0 && pb <= 0) return 2'b00;
    if (ta < tb) return 2'b01;
    if (tb < ta) return 2'b10;
    return 2'b11;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(3);
    total++;
    if ({bus.counter_flag, bus.LED, bus.busy, bus.time_a, bus.time_b,
         bus.foul_a, bus.foul_b, bus.winner} !== 28'd0)
      $display("FAIL reset_hold outputs: got flag=%b led=%b busy=%b ta=%0d tb=%0d fa=%b fb=%b w=%b required all 0",
               bus.counter_flag, bus.LED, bus.busy, bus.time_a, bus.time_b, bus.foul_a, bus.foul_b, bus.winner);
    else passed++;
    rst_n = 1'b1;
    cyc(5);
    total++;
    if ({bus.counter_flag, bus.LED, bus.busy, bus.winner} !== 6'd0)
      $display("FAIL reset_idle: got flag=%b led=%b busy=%b w=%b required 00/0/0/00",
               bus.counter_flag, bus.LED, bus.busy, bus.winner);
    else passed++;
    $display("reset: flag=%b led=%b busy=%b", bus.counter_flag, bus.LED, bus.busy);
  endtask

  // One full round: A presses when the counter reads pa (and again at rep_a),
  // B at pb; values <= 0 mean no press.
  task automatic test_round(input int pa, input int pb, input int rep_a, input string nm);
    bit ok;
    int ha, hb;
    logic [9:0] last;
    logic [1:0] ew;
    int ea, eb;
    do_start;
    ok = 1'b0; ha = 0; hb = 0; last = cnt_m;
    for (int i = 0; i < 9000; i++) begin
      cyc(1);
      if (ha > 0) begin ha--; if (ha == 0) bus.stop_a = 1'b0; end
      if (hb > 0) begin hb--; if (hb == 0) bus.stop_b = 1'b0; end
      if (bus.counter_flag == 2'b01) begin ok = 1'b1; break; end
      if (bus.LED && cnt_m != last) begin
        if (int'(cnt_m) == pa || int'(cnt_m) == rep_a) begin bus.stop_a = 1'b1; ha = 4; end
        if (int'(cnt_m) == pb) begin bus.stop_b = 1'b1; hb = 4; end
      end
      last = cnt_m;
    end
    bus.stop_a = 1'b0;
    bus.stop_b = 1'b0;
    total++;
    if (!ok) begin
      $display("FAIL %s done_timeout: got flag=%b required 01 within bound", nm, bus.counter_flag);
      return;
    end
    passed++;
    ea = (pa > 0) ? pa : CMAX;
    eb = (pb > 0) ? pb : CMAX;
    ew = ref_winner(pa, pb);
    total++;
    if (int'(bus.time_a) !== ea) $display("FAIL %s time_a: got %0d required %0d", nm, bus.time_a, ea);
    else passed++;
    total++;
    if (int'(bus.time_b) !== eb) $display("FAIL %s time_b: got %0d required %0d", nm, bus.time_b, eb);
    else passed++;
    total++;
    if (bus.winner !== ew) $display("FAIL %s winner: got %b required %b", nm, bus.winner, ew);
    else passed++;
    total++;
    if ({bus.LED, bus.busy, bus.foul_a, bus.foul_b} !== 4'b0000)
      $display("FAIL %s done_status: got led=%b busy=%b fa=%b fb=%b required 0000",
               nm, bus.LED, bus.busy, bus.foul_a, bus.foul_b);
    else passed++;
    // Stop presses after the round must not disturb the results.
    bus.stop_a = 1'b1; bus.stop_b = 1'b1;
    cyc(4);
    bus.stop_a = 1'b0; bus.stop_b = 1'b0;
    cyc(4);
    total++;
    if (int'(bus.time_a) !== ea || int'(bus.time_b) !== eb || bus.winner !== ew || bus.counter_flag !== 2'b01)
      $display("FAIL %s done_hold: got ta=%0d tb=%0d w=%b flag=%b required %0d %0d %b 01",
               nm, bus.time_a, bus.time_b, bus.winner, bus.counter_flag, ea, eb, ew);
    else passed++;
    $display("round %s: ta=%0d tb=%0d winner=%b (ref %0d %0d %b)", nm, bus.time_a, bus.time_b, bus.winner, ea, eb, ew);
  endtask

  task automatic test_foul(input bit fa, input bit fb);
    bit ok;
    int led0;
    logic [1:0] ew;
    ew = (fa && fb) ? 2'b00 : (fa ? 2'b10 : 2'b01);
    led0 = led_cycles;
    do_start;
    wait_for(0, 50, ok);
    total++;
    if (!ok) begin $display("FAIL foul busy_timeout: got busy=%b required 1", bus.busy); return; end
    passed++;
    cyc(3);
    bus.stop_a = fa; bus.stop_b = fb;
    cyc(1);
    wait_for(3, 60, ok);
    cyc(4);
    bus.stop_a = 1'b0; bus.stop_b = 1'b0;
    total++;
    if (!ok) begin $display("FAIL foul end_timeout: got busy=%b required 0", bus.busy); return; end
    passed++;
    total++;
    if ({bus.foul_a, bus.foul_b} !== {fa, fb})
      $display("FAIL foul_flags: got %b%b required %b%b", bus.foul_a, bus.foul_b, fa, fb);
    else passed++;
    total++;
    if (bus.winner !== ew) $display("FAIL foul_winner: got %b required %b", bus.winner, ew);
    else passed++;
    total++;
    if (led_cycles !== led0 || bus.counter_flag !== 2'b00)
      $display("FAIL foul_led_flag: got led_cycles=%0d flag=%b required %0d 00", led_cycles, bus.counter_flag, led0);
    else passed++;
    bus.stop_a = 1'b1; bus.stop_b = 1'b1;
    cyc(4);
    bus.stop_a = 1'b0; bus.stop_b = 1'b0;
    cyc(4);
    total++;
    if ({bus.foul_a, bus.foul_b} !== {fa, fb} || bus.winner !== ew || bus.busy !== 1'b0)
      $display("FAIL foul_hold: got fa=%b fb=%b w=%b busy=%b required %b %b %b 0",
               bus.foul_a, bus.foul_b, bus.winner, bus.busy, fa, fb, ew);
    else passed++;
    $display("foul a=%b b=%b: foul=%b%b winner=%b", fa, fb, bus.foul_a, bus.foul_b, bus.winner);
  endtask

  task automatic test_random_rounds;
    int pa, pb, rep;
    for (int r = 0; r < 6; r++) begin
      pa  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 900));
      pb  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 900));
      if ($urandom_range(0, 4) == 0) pb = pa;
      rep = (pa > 0 && $urandom_range(0, 1) == 1) ? pa + 7 : -1;
      test_round(pa, pb, rep, $sformatf("rand%0d", r));
    end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    do_start;
    wait_for(1, 400, ok);
    total++;
    if (!ok) begin $display("FAIL midrun led_timeout: got led=%b required 1", bus.LED); return; end
    passed++;
    cyc(20);
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.counter_flag, bus.LED, bus.busy} !== 4'b0000)
      $display("FAIL midrun_async: got flag=%b led=%b busy=%b required 00/0/0", bus.counter_flag, bus.LED, bus.busy);
    else passed++;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    total++;
    if ({bus.counter_flag, bus.LED, bus.busy, bus.time_a, bus.time_b,
         bus.foul_a, bus.foul_b, bus.winner} !== 28'd0)
      $display("FAIL midrun_idle: got flag=%b led=%b busy=%b ta=%0d tb=%0d w=%b required all 0",
               bus.counter_flag, bus.LED, bus.busy, bus.time_a, bus.time_b, bus.winner);
    else passed++;
    $display("reset mid-run: flag=%b led=%b busy=%b", bus.counter_flag, bus.LED, bus.busy);
  endtask

  task automatic test_wait_length;
    bit ok;
    int w, wmin, wmax;
    wmin = 1 << 30; wmax = 0;
    for (int r = 0; r < 50; r++) begin
      bus.start = 1'b1;
      w = 0; ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
        cyc(1);
        if (i == 4) bus.start = 1'b0;
        if (bus.LED) begin ok = 1'b1; break; end
        if (bus.busy) w++;
      end
      bus.start = 1'b0;
      total++;
      if (!ok || (w % CPM) != 0 || (w / CPM) < MIN || (w / CPM) > MIN + SPAN)
        $display("FAIL wait_len%0d: got %0d cycles (led=%b) required multiple of %0d in [%0d,%0d] ticks",
                 r, w, ok, CPM, MIN, MIN + SPAN);
      else passed++;
      if (w < wmin) wmin = w;
      if (w > wmax) wmax = w;
      bus.stop_a = 1'b1; bus.stop_b = 1'b1;
      wait_for(2, 60, ok);
      bus.stop_a = 1'b0; bus.stop_b = 1'b0;
      if (!ok) begin
        total++;
        $display("FAIL wait_len%0d done_timeout: got flag=%b required 01", r, bus.counter_flag);
        return;
      end
      $display("wait round %0d: %0d ticks", r, w / CPM);
      cyc(int'($urandom_range(2, 40)));
    end
    total++;
    if (wmax <= wmin) $display("FAIL wait_spread: got min=%0d max=%0d required max>min", wmin, wmax);
    else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop_a = 1'b0; bus.stop_b = 1'b0;
    test_reset;
    test_round(180, 245, -1, "a180_b245");
    test_round(200, 200, -1, "same_cycle_200");
    test_foul(1'b0, 1'b1);
    test_foul(1'b1, 1'b0);
    test_foul(1'b1, 1'b1);
    test_round(150, -1, -1, "a150_b_none");
    test_round(-1, -1, -1, "no_press");
    test_round(100, 300, 160, "repeat_a");
    test_round(400, 120, -1, "b_first");
    test_random_rounds;
    test_reset_mid_run;
    test_wait_length;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
